// File: rtl/sd_cmd_serializer.sv
// SD command-line transmitter: gathers a 5-byte command over a val/ack handshake,
// appends CRC7 and framing bits, and shifts the 48-bit frame out MSB first.
module sd_cmd_serializer #(
  parameter int WIDTH   = 8,
  parameter int N_BYTES = 5
) (
  input  logic             sd_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_val,
  output logic             in_ack,
  output logic             cmd_out,
  output logic             cmd_oe,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SHIFT, S_END} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        r_full, w_full_nxt;
  logic [5:0]  r_bitcnt, w_bitcnt_nxt;
  logic [39:0] r_payload, w_payload_nxt;
  logic [6:0]  r_crc, w_crc_nxt;
  logic        r_ack, w_ack_nxt;
  logic        r_cmd_out, w_cmd_out_nxt;
  logic        r_oe, w_oe_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;

  logic        w_take;
  logic [7:0]  w_byte;
  logic [5:0]  w_nb;
  logic [5:0]  w_pidx;

  function automatic logic [6:0] f_crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // A fresh command may start on the END->IDLE edge, so END accepts like IDLE.
  assign w_take = in_val && !r_ack &&
                  ((r_state == S_IDLE) || (r_state == S_END) ||
                   ((r_state == S_COLLECT) && !r_full));
  assign w_byte = (r_cnt == 3'd0) ? {2'b01, in_data[5:0]} : in_data[7:0];
  assign w_nb   = r_bitcnt - 6'd1;
  assign w_pidx = w_nb - 6'd8;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_full_nxt    = r_full;
    w_bitcnt_nxt  = r_bitcnt;
    w_payload_nxt = r_payload;
    w_crc_nxt     = r_crc;
    w_ack_nxt     = 1'b0;
    w_cmd_out_nxt = r_cmd_out;
    w_oe_nxt      = r_oe;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (r_full) begin
          w_state_nxt   = S_SHIFT;
          w_full_nxt    = 1'b0;
          w_cnt_nxt     = 3'd0;
          w_bitcnt_nxt  = 6'd47;
          w_cmd_out_nxt = r_payload[39];
          w_crc_nxt     = f_crc7_step(7'd0, r_payload[39]);
          w_oe_nxt      = 1'b1;
        end else if (w_take) begin
          w_ack_nxt     = 1'b1;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_COLLECT;
          w_payload_nxt = {r_payload[31:0], w_byte};
          if (r_cnt == 3'(N_BYTES - 1)) w_full_nxt = 1'b1;
          else                          w_cnt_nxt  = r_cnt + 3'd1;
        end
      end
      S_SHIFT: begin
        w_bitcnt_nxt = w_nb;
        if (w_nb >= 6'd8) begin
          w_cmd_out_nxt = r_payload[w_pidx];
          w_crc_nxt     = f_crc7_step(r_crc, r_payload[w_pidx]);
        end else if (w_nb != 6'd0) begin
          w_cmd_out_nxt = r_crc[6];
          w_crc_nxt     = {r_crc[5:0], 1'b0};
        end else begin
          w_cmd_out_nxt = 1'b1;
          w_state_nxt   = S_END;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_oe_nxt      = 1'b0;
        w_cmd_out_nxt = 1'b1;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b1;
        if (w_take) begin
          w_ack_nxt     = 1'b1;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_COLLECT;
          w_payload_nxt = {r_payload[31:0], w_byte};
          w_cnt_nxt     = 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_full    <= 1'b0;
      r_bitcnt  <= 6'd0;
      r_ack     <= 1'b0;
      r_cmd_out <= 1'b1;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_full    <= w_full_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_ack     <= w_ack_nxt;
      r_cmd_out <= w_cmd_out_nxt;
      r_oe      <= w_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Payload and CRC are reloaded before use, so they carry no reset.
  always_ff @(posedge sd_clk) begin
    r_payload <= w_payload_nxt;
    r_crc     <= w_crc_nxt;
  end

  assign in_ack  = r_ack;
  assign cmd_out = r_cmd_out;
  assign cmd_oe  = r_oe;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
